// File: rtl/ex_lsu.sv
// Execute-stage load/store unit: one data-memory transaction per instruction over a
// req/ready bus, RV32I alignment, lane steering, sign extension, flush kill and bus timeout.
`timescale 1ns/1ps
module ex_lsu #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] instr_ex,
   input  logic        ram_load_access_ex,
   input  logic        ram_store_access_ex,
   input  logic [31:0] ram_load_addr_ex,
   input  logic [31:0] ram_store_addr_ex,
   input  logic [31:0] ram_store_data_ex,
   output logic        lsu_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        load_valid,
   output logic [4:0]  load_rd,
   output logic [31:0] load_data,
   output logic        store_done,
   output logic        misalign_err,
   output logic        bus_err,
   output logic [31:0] err_addr,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          kill_q, kill_d;
   logic          is_load_q, is_load_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   addr_q, addr_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic          load_valid_q, load_valid_d, store_done_q, store_done_d;
   logic          misalign_err_q, misalign_err_d, bus_err_q, bus_err_d;
   logic [4:0]    load_rd_q, load_rd_d;
   logic [31:0]   load_data_q, load_data_d, err_addr_q, err_addr_d;

   logic          acc;
   logic [2:0]    f3;
   logic [31:0]   sel_addr;
   logic          legal, aligned;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   ext;
   logic          unused_instr;

   assign unused_instr = ^{instr_ex[31:15], instr_ex[6:0]};

   assign acc      = ram_load_access_ex | ram_store_access_ex;
   assign f3       = instr_ex[14:12];
   assign sel_addr = ram_load_access_ex ? ram_load_addr_ex : ram_store_addr_ex;
   assign lsu_busy = ((state_q == S_IDLE) & acc & ~flush) | (state_q == S_REQ);

   always_comb begin
      legal = ram_load_access_ex ? (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111)
                                 : (f3[2] == 1'b0 && f3[1:0] != 2'b11);
      case (f3[1:0])
         2'b10:   aligned = (sel_addr[1:0] == 2'b00);
         2'b01:   aligned = ~sel_addr[0];
         default: aligned = 1'b1;
      endcase
      case (f3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << sel_addr[1:0];
            st_wdata = {4{ram_store_data_ex[7:0]}};
         end
         2'b01: begin
            st_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ram_store_data_ex[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = ram_store_data_ex;
         end
      endcase
   end

   // Load extraction uses the latched byte address, so it is ready in the ready cycle.
   always_comb begin
      lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  ext = {24'd0, lane_b};
         3'b001:  ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  ext = {16'd0, lane_h};
         default: ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      kill_d         = kill_q;
      is_load_d      = is_load_q;
      funct3_d       = funct3_q;
      rd_d           = rd_q;
      addr_d         = addr_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_be_d       = mem_be_q;
      load_rd_d      = load_rd_q;
      load_data_d    = load_data_q;
      err_addr_d     = err_addr_q;
      load_valid_d   = 1'b0;
      store_done_d   = 1'b0;
      misalign_err_d = 1'b0;
      bus_err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (acc && !flush) begin
               funct3_d  = f3;
               rd_d      = instr_ex[11:7];
               addr_d    = sel_addr;
               is_load_d = ram_load_access_ex;
               kill_d    = 1'b0;
               cnt_d     = '0;
               if (legal && aligned) begin
                  state_d     = S_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = ~ram_load_access_ex;
                  mem_addr_d  = {sel_addr[31:2], 2'b00};
                  mem_be_d    = ram_load_access_ex ? 4'b0000 : st_be;
                  mem_wdata_d = ram_load_access_ex ? 32'd0 : st_wdata;
               end else begin
                  state_d        = S_RESP;
                  misalign_err_d = 1'b1;
                  err_addr_d     = sel_addr;
               end
            end
         end
         S_REQ: begin
            if (flush) kill_d = 1'b1;
            if (mem_ready) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               if (!is_load_q) begin
                  store_done_d = 1'b1;
               end else if (!(kill_q || flush)) begin
                  load_valid_d = 1'b1;
                  load_data_d  = ext;
                  load_rd_d    = rd_q;
               end
            end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
               state_d    = S_RESP;
               mem_req_d  = 1'b0;
               bus_err_d  = 1'b1;
               err_addr_d = addr_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         kill_q         <= 1'b0;
         is_load_q      <= 1'b0;
         funct3_q       <= 3'd0;
         rd_q           <= 5'd0;
         addr_q         <= 32'd0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'd0;
         mem_wdata_q    <= 32'd0;
         mem_be_q       <= 4'd0;
         load_valid_q   <= 1'b0;
         load_rd_q      <= 5'd0;
         load_data_q    <= 32'd0;
         store_done_q   <= 1'b0;
         misalign_err_q <= 1'b0;
         bus_err_q      <= 1'b0;
         err_addr_q     <= 32'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         kill_q         <= kill_d;
         is_load_q      <= is_load_d;
         funct3_q       <= funct3_d;
         rd_q           <= rd_d;
         addr_q         <= addr_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_be_q       <= mem_be_d;
         load_valid_q   <= load_valid_d;
         load_rd_q      <= load_rd_d;
         load_data_q    <= load_data_d;
         store_done_q   <= store_done_d;
         misalign_err_q <= misalign_err_d;
         bus_err_q      <= bus_err_d;
         err_addr_q     <= err_addr_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_be       = mem_be_q;
   assign load_valid   = load_valid_q;
   assign load_rd      = load_rd_q;
   assign load_data    = load_data_q;
   assign store_done   = store_done_q;
   assign misalign_err = misalign_err_q;
   assign bus_err      = bus_err_q;
   assign err_addr     = err_addr_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ex_lsu.sv
// Bench for ex_lsu: directed cases plus randomized accesses checked against an
// arithmetic model of the RV32I load/store rules and a queue of expected load results.
`timescale 1ns/1ps
module tb_ex_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] instr_ex = 32'd0;
   logic        ram_load_access_ex = 1'b0;
   logic        ram_store_access_ex = 1'b0;
   logic [31:0] ram_load_addr_ex = 32'd0;
   logic [31:0] ram_store_addr_ex = 32'd0;
   logic [31:0] ram_store_data_ex = 32'd0;
   logic        lsu_busy, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        load_valid, store_done, misalign_err, bus_err;
   logic [4:0]  load_rd;
   logic [31:0] load_data, err_addr;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   logic [36:0] exp_q[$];
   logic [31:0] exp_err = 32'd0;

   ex_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .flush(flush), .instr_ex(instr_ex),
      .ram_load_access_ex(ram_load_access_ex), .ram_store_access_ex(ram_store_access_ex),
      .ram_load_addr_ex(ram_load_addr_ex), .ram_store_addr_ex(ram_store_addr_ex),
      .ram_store_data_ex(ram_store_data_ex), .lsu_busy(lsu_busy), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .load_valid(load_valid),
      .load_rd(load_rd), .load_data(load_data), .store_done(store_done),
      .misalign_err(misalign_err), .bus_err(bus_err), .err_addr(err_addr),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: extract and extend by shifting the word arithmetically.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (8 * (a & 32'd2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // scoreboard: every load_valid must match the oldest expected {rd, data}
   always @(negedge clk) begin
      if (!rst && load_valid) begin
         if (exp_q.size() == 0) begin
            check("load_unexpected", 32'd1, 32'd0);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("load_data", load_data, e[31:0]);
            check("load_rd", {27'd0, load_rd}, {27'd0, e[36:32]});
         end
      end
   end

   // waits < 0 means ready never comes; flush_at is the REQ cycle index for a flush, -1 none
   task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] la, input logic [31:0] sa,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int waits, input int flush_at);
      logic [31:0] ea, exp_be, exp_wd, exp_ld;
      logic legal, ok, killed, timed_out, is_ld;
      int n;
      is_ld  = ld;
      ea     = ld ? la : sa;
      legal  = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
      ok     = legal && ((ea % (32'd1 << f3[1:0])) == 32'd0);
      exp_be = ld ? 32'd0 : (f3 == 3'd0) ? (32'd1 << ea[1:0]) :
               (f3 == 3'd1) ? (32'd3 << ea[1:0]) : 32'hF;
      exp_wd = ld ? 32'd0 : (f3 == 3'd0) ? wd[7:0] * 32'h0101_0101 :
               (f3 == 3'd1) ? wd[15:0] * 32'h0001_0001 : wd;
      exp_ld = model_load(f3, ea, rdata);

      @(posedge clk); #1;
      ram_load_access_ex  = ld;
      ram_store_access_ex = st;
      ram_load_addr_ex    = la;
      ram_store_addr_ex   = sa;
      ram_store_data_ex   = wd;
      instr_ex            = $urandom;
      instr_ex[14:12]     = f3;
      instr_ex[11:7]      = rd;
      @(negedge clk);
      check("accept_busy", {31'd0, lsu_busy}, 32'd1);
      check("accept_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      ram_load_access_ex  = 1'b0;
      ram_store_access_ex = 1'b0;
      if (!ok) begin
         exp_err = ea;
         @(negedge clk);
         check("mis_err", {31'd0, misalign_err}, 32'd1);
         check("mis_addr", err_addr, exp_err);
         check("mis_req", {31'd0, mem_req}, 32'd0);
         check("mis_busy", {31'd0, lsu_busy}, 32'd0);
         check("mis_lv", {31'd0, load_valid}, 32'd0);
         return;
      end
      killed    = 1'b0;
      timed_out = 1'b0;
      for (n = 0; n < 100; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
         end
         mem_ready = (n == waits);
         mem_rdata = (n == waits) ? rdata : $urandom;
         flush     = (n == flush_at);
         if (n == flush_at) killed = 1'b1;
         @(negedge clk);
         check("req_req", {31'd0, mem_req}, 32'd1);
         check("req_busy", {31'd0, lsu_busy}, 32'd1);
         check("req_addr", mem_addr, ea & 32'hFFFF_FFFC);
         check("req_we", {31'd0, mem_we}, {31'd0, ~is_ld});
         check("req_be", {28'd0, mem_be}, exp_be);
         if (!is_ld) check("req_wdata", mem_wdata, exp_wd);
         if (n == waits) break;
         if (waits < 0 && n == TO - 1) begin
            timed_out = 1'b1;
            break;
         end
      end
      if (n == 100) check("req_bound", 32'd0, 32'd1);
      if (is_ld && !killed && !timed_out) exp_q.push_back({rd, exp_ld});
      if (timed_out) exp_err = ea;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      flush     = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      check("resp_lv", {31'd0, load_valid}, {31'd0, is_ld && !killed && !timed_out});
      check("resp_sd", {31'd0, store_done}, {31'd0, !is_ld && !timed_out});
      check("resp_be", {31'd0, bus_err}, {31'd0, timed_out});
      check("resp_mis", {31'd0, misalign_err}, 32'd0);
      check("resp_req", {31'd0, mem_req}, 32'd0);
      check("resp_busy", {31'd0, lsu_busy}, 32'd0);
      check("resp_erraddr", err_addr, exp_err);
   endtask

   initial begin
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] la, sa;
      int waits, fl;

      #3;
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_busy", {31'd0, lsu_busy}, 32'd0);
      check("rst_outs", {26'd0, load_valid, store_done, misalign_err, bus_err, mem_we, 1'b0},
            32'd0);
      check("rst_erraddr", err_addr, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_access(1, 0, 3'd2, 5'd5, 32'h100, 32'h0, 32'h0, 32'h8000_00F1, 0, -1);
      run_access(1, 0, 3'd0, 5'd6, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 0, -1);
      run_access(1, 0, 3'd4, 5'd7, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 0, -1);
      run_access(1, 0, 3'd1, 5'd8, 32'h102, 32'h0, 32'h0, 32'h8001_1234, 0, -1);
      run_access(0, 1, 3'd0, 5'd0, 32'h0, 32'h201, 32'h0000_00AB, 32'h0, 0, -1);
      run_access(0, 1, 3'd1, 5'd0, 32'h0, 32'h202, 32'h0000_1234, 32'h0, 1, -1);
      run_access(1, 0, 3'd2, 5'd9, 32'h102, 32'h0, 32'h0, 32'h0, 0, -1);
      run_access(1, 0, 3'd2, 5'd10, 32'h110, 32'h0, 32'h0, 32'h1234_5678, 3, 1);
      run_access(1, 0, 3'd2, 5'd11, 32'h120, 32'h0, 32'h0, 32'h0, -1, -1);
      run_access(1, 0, 3'd5, 5'd12, 32'h132, 32'h0, 32'h0, 32'hCAFE_BEEF, 3, -1);
      run_access(1, 1, 3'd0, 5'd13, 32'h141, 32'h202, 32'h55, 32'h0000_F100, 0, -1);
      run_access(0, 1, 3'd3, 5'd0, 32'h0, 32'h300, 32'h1, 32'h0, 0, -1);

      // reset in the middle of a request: outputs must drop with no clock edge
      @(posedge clk); #1;
      ram_load_access_ex = 1'b1;
      ram_load_addr_ex   = 32'h300;
      instr_ex           = 32'h0000_2083;
      @(posedge clk); #1;
      ram_load_access_ex = 1'b0;
      @(negedge clk);
      check("mid_req_before", {31'd0, mem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_busy", {31'd0, lsu_busy}, 32'd0);
      check("mid_rst_erraddr", err_addr, 32'd0);
      exp_err = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_access(1, 0, 3'd2, 5'd14, 32'h304, 32'h0, 32'h0, 32'hA5A5_0F0F, 0, -1);

      for (int i = 0; i < 60; i++) begin
         ld = 1'($urandom_range(0, 1));
         st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
         f3 = 3'($urandom_range(0, 7));
         la = $urandom;
         sa = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            la[0] = 1'b0;
            sa[0] = 1'b0;
         end
         waits = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) waits = -1;
         fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (waits < 0) ? 3 : waits) : -1;
         run_access(ld, st, f3, 5'($urandom_range(0, 31)), la, sa, $urandom, $urandom, waits, fl);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
